// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read side plus serial line and status of the UART drain
interface uart_tx_fifo_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_r_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    modport master (
        input  fifo_empty, fifo_r_data,
        output fifo_r_en, tx, tx_busy, tx_done
    );
    modport slave (
        output fifo_empty, fifo_r_data,
        input  fifo_r_en, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a first-word-fall-through FIFO and sends them as UART frames
module uart_tx_fifo_drain #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic clk,
    input logic rst,
    uart_tx_fifo_drain_if.master bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic          tick;
    logic          bit_end;
    assign tick    = div_cnt == DW'(DIV - 1);
    assign bit_end = tick && tick_cnt == 4'd15;
    // Pop is combinational so the byte is captured on the same edge that leaves IDLE
    assign bus.fifo_r_en = state == IDLE && !bus.fifo_empty && !rst;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            bus.tx      <= 1'b1;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                if (!bus.fifo_empty) begin
                    shift_reg   <= bus.fifo_r_data;
                    par_bit     <= ^bus.fifo_r_data ^ (PARITY_ODD != 0);
                    state       <= START;
                    bus.tx      <= 1'b0;
                    bus.tx_busy <= 1'b1;
                end
            end else begin
                div_cnt  <= tick ? '0 : div_cnt + 1'b1;
                tick_cnt <= tick ? tick_cnt + 4'd1 : tick_cnt;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state   <= DATA;
                            bus.tx  <= shift_reg[0];
                            bit_cnt <= '0;
                        end
                        DATA: begin
                            if (bit_cnt == 3'd7) begin
                                state   <= PARITY_EN != 0 ? PARITY : STOP;
                                bus.tx  <= PARITY_EN != 0 ? par_bit : 1'b1;
                                bit_cnt <= '0;
                            end else begin
                                shift_reg <= shift_reg >> 1;
                                bus.tx    <= shift_reg[1];
                                bit_cnt   <= bit_cnt + 3'd1;
                            end
                        end
                        PARITY: begin
                            state   <= STOP;
                            bus.tx  <= 1'b1;
                            bit_cnt <= '0;
                        end
                        STOP: begin
                            if (bit_cnt == 3'(STOP_BITS - 1)) begin
                                state       <= IDLE;
                                bus.tx_done <= 1'b1;
                                bus.tx_busy <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: directed vectors against four parameterisations of the UART drain
module tb_uart_tx_fifo_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tx_v[4];
    logic       busy_v[4];
    logic       done_v[4];
    logic       ren_v[4];
    logic [7:0] mem[4][16];
    logic [3:0] rd[4] = '{default: 4'd0};
    logic [3:0] wr[4] = '{default: 4'd0};
    int         pops[4] = '{default: 0};
    int         viol = 0;
    int         checks = 0;
    int         failures = 0;

    // 0: DIV=1 8N1, 1: even parity 2 stop, 2: odd parity 2 stop, 3: DIV=3 8N1
    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo_drain_if u_if ();
        uart_tx_fifo_drain #(
            .CLK_FREQ  (g == 3 ? 4_800_000 : 1_600_000),
            .BAUD      (100_000),
            .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD(g == 2 ? 1 : 0),
            .STOP_BITS ((g == 1 || g == 2) ? 2 : 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(u_if.master)
        );
        assign u_if.fifo_empty  = rd[g] == wr[g];
        assign u_if.fifo_r_data = mem[g][rd[g]];
        assign tx_v[g]   = u_if.tx;
        assign busy_v[g] = u_if.tx_busy;
        assign done_v[g] = u_if.tx_done;
        assign ren_v[g]  = u_if.fifo_r_en;
    end

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (ren_v[i]) begin
                rd[i]   <= rd[i] + 4'd1;
                pops[i] <= pops[i] + 1;
            end

    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (ren_v[i] && (busy_v[i] || rd[i] == wr[i])) viol <= viol + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wr[d]] = b;
        wr[d] = wr[d] + 4'd1;
    endtask

    task automatic frame(input int d, input logic [11:0] bits, input int nbits,
                         input int len, input int gap, input string name);
        int per = d == 3 ? 48 : 16;
        int idle = 0;
        int busy_n = 0;
        int dlen = -1;
        logic [11:0] got = '0;
        while (tx_v[d] !== 1'b0 && idle < 300) begin
            @(negedge clk);
            idle++;
        end
        for (int c = 0; c < nbits * per + 8 && idle < 300; c++) begin
            if (c % per == per / 2 && c / per < nbits) got[c / per] = tx_v[d];
            if (busy_v[d]) busy_n++;
            if (done_v[d]) begin
                dlen = c;
                break;
            end
            @(negedge clk);
        end
        check({name, "_bits"}, int'(got), int'(bits));
        check({name, "_len"}, dlen, len);
        check({name, "_busy"}, busy_n, len);
        if (gap >= 0) check({name, "_gap"}, idle, gap);
    endtask

    typedef struct {
        int          d;
        int          npush;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nbits;
        int          len;
        int          gap;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int bad;
        int p;
        tbl[0] = '{0, 1, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10, 160, -1};
        tbl[1] = '{0, 3, 8'h00, 12'({1'b1, 8'h00, 1'b0}), 10, 160, -1};
        tbl[2] = '{0, 0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}), 10, 160, 1};
        tbl[3] = '{0, 0, 8'h55, 12'({1'b1, 8'h55, 1'b0}), 10, 160, 1};
        tbl[4] = '{1, 1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 192, -1};
        tbl[5] = '{2, 1, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0}, 12, 192, -1};
        tbl[6] = '{3, 1, 8'h41, 12'({1'b1, 8'h41, 1'b0}), 10, 480, -1};

        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx_v[0]), 1);
        check("rst_busy", int'(busy_v[0]), 0);
        check("rst_done", int'(done_v[0]), 0);
        check("rst_ren", int'(ren_v[0]), 0);
        rst = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || ren_v[0] !== 1'b0) bad++;
        end
        check("empty_idle_bad", bad, 0);
        check("empty_pops", pops[0], 0);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < tbl[i].npush; k++) push(tbl[i].d, tbl[i + k].data);
            frame(tbl[i].d, tbl[i].bits, tbl[i].nbits, tbl[i].len, tbl[i].gap,
                  $sformatf("vec%0d", i));
        end

        push(0, 8'h3C);
        bad = 0;
        while (tx_v[0] !== 1'b0 && bad < 300) begin
            @(negedge clk);
            bad++;
        end
        repeat (70) @(negedge clk);
        check("mid_busy_before", int'(busy_v[0]), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", int'(tx_v[0]), 1);
        check("mid_rst_busy", int'(busy_v[0]), 0);
        check("mid_rst_done", int'(done_v[0]), 0);
        check("mid_rst_ren", int'(ren_v[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = pops[0];
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        check("post_rst_no_pop", pops[0], p);
        check("post_rst_idle_bad", bad, 0);
        push(0, 8'h81);
        frame(0, 12'({1'b1, 8'h81, 1'b0}), 10, 160, -1, "post_rst");
        repeat (4) @(negedge clk);

        check("pops0", pops[0], 6);
        check("pops1", pops[1], 1);
        check("pops2", pops[2], 1);
        check("pops3", pops[3], 1);
        check("ren_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
